// File: rtl/imem_controller_pkg.sv
// Shared types and constants for the instruction-memory controller slice.
package imem_ctrl_pkg;

    // Controller sequencing: program load, then normal fetch service.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } imem_state_e;

    localparam int IMEM_DEPTH  = 256;
    localparam int IMEM_WIDTH  = 32;
    localparam int PC_W        = 32;
    // Byte address to word index shift.
    localparam int WORD_OFFSET = 2;

endpackage

// File: rtl/imem_controller_if.sv
// Load, fetch, debug and memory-port signals of the instruction-memory
// controller. The controller uses the slave view; its environment
// (loader, core, debugger, memory macro) uses the master view.
interface imem_controller_if
    import imem_ctrl_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int WIDTH = IMEM_WIDTH
);
    localparam int AW = $clog2(DEPTH);

    // Program load port
    logic             ld_valid;
    logic             ld_ready;
    logic [WIDTH-1:0] ld_data;
    logic             ld_last;
    logic             reload;

    // Core fetch path
    logic [PC_W-1:0]  fetch_pc;
    logic [WIDTH-1:0] fetch_instr;
    logic             core_stall;
    logic             misalign_err;
    logic [AW:0]      boot_words;

    // Debug read port
    logic             dbg_req;
    logic [AW-1:0]    dbg_addr;
    logic             dbg_gnt;
    logic             dbg_rvalid;
    logic [WIDTH-1:0] dbg_rdata;

    // Single-port memory
    logic [AW-1:0]    mem_addr;
    logic             mem_we;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  ld_valid, ld_data, ld_last, reload,
        input  fetch_pc, dbg_req, dbg_addr, mem_rdata,
        output ld_ready, fetch_instr, core_stall, misalign_err, boot_words,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output ld_valid, ld_data, ld_last, reload,
        output fetch_pc, dbg_req, dbg_addr, mem_rdata,
        input  ld_ready, fetch_instr, core_stall, misalign_err, boot_words,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/imem_controller_dbg_arb.sv
// Two-requester alternating arbiter for the memory read port: the debug
// requester is never granted on two consecutive cycles, so the core owns
// the port at least every other cycle.
module imem_dbg_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic en_i,
    output logic gnt_o
);

    logic gnt_prev_q;

    assign gnt_o = req_i && en_i && !gnt_prev_q;

    // Remember whether debug held the port last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_prev_q <= 1'b0;
        end else begin
            gnt_prev_q <= gnt_o;
        end
    end

endmodule

// File: rtl/imem_controller.sv
// Instruction-memory sequencer/arbiter: streams a program into memory in
// BOOT while stalling the core, then serves core fetches in RUN.
// Optional debug read port enabled by defining IMEM_CTRL_DBG_EN.
module imem_controller
    import imem_ctrl_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int WIDTH = IMEM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    imem_controller_if.slave bus
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

    imem_state_e      state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [AW:0]      boot_words_q, boot_words_d;
    logic             misalign_q, misalign_d;
    logic [WIDTH-1:0] fetch_instr_q;

    logic             ld_ready_c;
    logic             core_stall_c;
    logic             mem_we_c;
    logic [AW-1:0]    mem_addr_c;
    logic [WIDTH-1:0] fetch_instr_c;
    logic             dbg_gnt;

    logic [AW-1:0]    pc_index;
    logic             pc_misaligned;
    logic             unused_pc_hi;

    // Upper PC bits are dropped so fetch addresses wrap modulo DEPTH.
    assign pc_index      = bus.fetch_pc[WORD_OFFSET +: AW];
    assign pc_misaligned = |bus.fetch_pc[WORD_OFFSET-1:0];
    assign unused_pc_hi  = ^bus.fetch_pc[PC_W-1:AW+WORD_OFFSET];

`ifdef IMEM_CTRL_DBG_EN
    logic             arb_en;
    logic             dbg_rvalid_q;
    logic [WIDTH-1:0] dbg_rdata_q;

    // A reload cycle hands the port back to the loader, so no grant then.
    assign arb_en = (state_q == RUN) && !bus.reload;

    imem_dbg_arb u_dbg_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (bus.dbg_req),
        .en_i  (arb_en),
        .gnt_o (dbg_gnt)
    );

    // Capture the debug word one cycle after its grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            dbg_rvalid_q <= dbg_gnt;
            if (dbg_gnt) begin
                dbg_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.dbg_rdata  = dbg_rdata_q;
`else
    logic unused_dbg;

    assign dbg_gnt        = 1'b0;
    assign bus.dbg_rvalid = 1'b0;
    assign bus.dbg_rdata  = '0;
    assign unused_dbg     = bus.dbg_req ^ (^bus.dbg_addr);
`endif

    // Next-state and port steering for load, fetch and debug ownership.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        boot_words_d  = boot_words_q;
        misalign_d    = misalign_q;
        ld_ready_c    = 1'b0;
        core_stall_c  = 1'b1;
        mem_we_c      = 1'b0;
        mem_addr_c    = ptr_q;
        fetch_instr_c = fetch_instr_q;

        unique case (state_q)
            BOOT: begin
                ld_ready_c = 1'b1;
                if (bus.ld_valid) begin
                    mem_we_c = 1'b1;
                    ptr_d    = ptr_q + PTR_ONE;
                    if (bus.ld_last || (ptr_q == PTR_LAST)) begin
                        state_d      = RUN;
                        boot_words_d = {1'b0, ptr_q} + CNT_ONE;
                        ptr_d        = '0;
                    end
                end
            end
            RUN: begin
                if (dbg_gnt) begin
                    mem_addr_c   = bus.dbg_addr;
                    core_stall_c = 1'b1;
                end else begin
                    mem_addr_c    = pc_index;
                    core_stall_c  = 1'b0;
                    fetch_instr_c = bus.mem_rdata;
                    if (pc_misaligned) begin
                        misalign_d = 1'b1;
                    end
                end
                if (bus.reload) begin
                    state_d = BOOT;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = BOOT;
                ptr_d   = '0;
            end
        endcase
    end

    // Controller state; fetch_instr_q replays the last word during debug grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            ptr_q         <= '0;
            boot_words_q  <= '0;
            misalign_q    <= 1'b0;
            fetch_instr_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            boot_words_q  <= boot_words_d;
            misalign_q    <= misalign_d;
            fetch_instr_q <= fetch_instr_c;
        end
    end

    assign bus.ld_ready     = ld_ready_c;
    assign bus.core_stall   = core_stall_c;
    assign bus.mem_we       = mem_we_c;
    assign bus.mem_addr     = mem_addr_c;
    assign bus.mem_wdata    = bus.ld_data;
    assign bus.fetch_instr  = fetch_instr_c;
    assign bus.misalign_err = misalign_q;
    assign bus.boot_words   = boot_words_q;
    assign bus.dbg_gnt      = dbg_gnt;

endmodule

// File: tb/tb_imem_controller.sv
// Self-checking bench for imem_controller with a behavioural memory,
// a write/debug-read scoreboard and table-driven fetch/debug vectors.
module tb_imem_controller;
    import imem_ctrl_pkg::*;

    localparam int DEPTH = 256;
    localparam int WIDTH = 32;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_controller_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    imem_controller #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural single-port memory: combinational read, synchronous write.
    logic [WIDTH-1:0] mem [DEPTH];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    wr_t              exp_wr_q [$];
    logic [WIDTH-1:0] exp_dbg_q [$];
    wr_t              mon_wr;
    logic [WIDTH-1:0] mon_dbg;

    int ptr_m;
    bit in_boot_m;
    int boot_words_m;

    function automatic logic [WIDTH-1:0] word_of(input int gen, input int idx);
        return 32'(gen) * 32'h0100_0000 + 32'(idx) * 32'h0001_0003 + 32'h0000_0055;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write and every debug read return is popped and compared.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.mem_we === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: actual addr=%0d data=0x%0h required=no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                mon_wr = exp_wr_q.pop_front();
                chk("wr_addr", 64'(bus.mem_addr), 64'(mon_wr.addr));
                chk("wr_data", 64'(bus.mem_wdata), 64'(mon_wr.data));
            end
        end
        if (rst_n === 1'b1 && bus.dbg_rvalid === 1'b1) begin
            if (exp_dbg_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_dbg_rvalid: actual rdata=0x%0h required=no rvalid",
                         bus.dbg_rdata);
            end else begin
                mon_dbg = exp_dbg_q.pop_front();
                chk("dbg_rdata", 64'(bus.dbg_rdata), 64'(mon_dbg));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ld_ready"},     64'(bus.ld_ready),     64'(1));
        chk({tag, "_core_stall"},   64'(bus.core_stall),   64'(1));
        chk({tag, "_mem_we"},       64'(bus.mem_we),       64'(0));
        chk({tag, "_dbg_gnt"},      64'(bus.dbg_gnt),      64'(0));
        chk({tag, "_dbg_rvalid"},   64'(bus.dbg_rvalid),   64'(0));
        chk({tag, "_dbg_rdata"},    64'(bus.dbg_rdata),    64'(0));
        chk({tag, "_misalign_err"}, 64'(bus.misalign_err), 64'(0));
        chk({tag, "_boot_words"},   64'(bus.boot_words),   64'(0));
        chk({tag, "_fetch_instr"},  64'(bus.fetch_instr),  64'(0));
    endtask

    // Streams n words; the model decides which are accepted and where they land.
    task automatic load_words(input int gen, input int n, input bit use_last, input bit toggle);
        bit exp_boot;
        for (int i = 0; i < n; i++) begin
            if (toggle && (i % 3 == 1)) begin
                @(posedge clk); #1;
                bus.ld_valid = 1'b0;
                bus.ld_last  = 1'b0;
                @(negedge clk);
                chk("idle_ld_ready", 64'(bus.ld_ready), 64'(in_boot_m));
            end
            @(posedge clk); #1;
            bus.ld_valid = 1'b1;
            bus.ld_data  = word_of(gen, i);
            bus.ld_last  = use_last && (i == n - 1);
            exp_boot     = in_boot_m;
            if (in_boot_m) begin
                exp_wr_q.push_back('{addr: AW'(ptr_m), data: word_of(gen, i)});
                ptr_m++;
                if (bus.ld_last || ptr_m == DEPTH) begin
                    in_boot_m    = 1'b0;
                    boot_words_m = ptr_m;
                end
            end
            @(negedge clk);
            chk("load_ld_ready",   64'(bus.ld_ready),   64'(exp_boot));
            chk("load_core_stall", 64'(bus.core_stall), 64'(exp_boot));
        end
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        @(negedge clk);
        chk("post_load_core_stall", 64'(bus.core_stall), 64'(in_boot_m));
        chk("post_load_boot_words", 64'(bus.boot_words), 64'(boot_words_m));
    endtask

    task automatic do_reload();
        @(posedge clk); #1;
        bus.reload  = 1'b1;
        bus.dbg_req = 1'b1;
        bus.dbg_addr = AW'(7);
        @(negedge clk);
        chk("reload_dbg_gnt",    64'(bus.dbg_gnt),    64'(0));
        chk("reload_core_stall", 64'(bus.core_stall), 64'(0));
        @(posedge clk); #1;
        bus.reload = 1'b0;
        ptr_m      = 0;
        in_boot_m  = 1'b1;
        @(negedge clk);
        chk("boot_dbg_gnt",    64'(bus.dbg_gnt),    64'(0));
        chk("boot_ld_ready",   64'(bus.ld_ready),   64'(1));
        chk("boot_core_stall", 64'(bus.core_stall), 64'(1));
        chk("boot_words_kept", 64'(bus.boot_words), 64'(boot_words_m));
        bus.dbg_req = 1'b0;
    endtask

    typedef struct {
        logic [31:0]      pc;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] instr;
        logic             mis;
    } fetch_vec_t;

    typedef struct {
        logic          req;
        logic          gnt;
        logic          stall;
        logic          rvalid;
        logic [AW-1:0] addr;
    } dbg_vec_t;

    fetch_vec_t fv [7];
    dbg_vec_t   dv [4];

    initial begin
        #1ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hEE00_0000 | 32'(i);

        // Row mis = misalign_err observed during that row (it registers one edge later).
        fv[0] = '{32'h0000_0000, 8'd0,  word_of(1, 0),  1'b0};
        fv[1] = '{32'h0000_0048, 8'd18, word_of(1, 18), 1'b0};
        fv[2] = '{32'h0000_0024, 8'd9,  word_of(1, 9),  1'b0};
        fv[3] = '{32'h0000_0410, 8'd4,  word_of(1, 4),  1'b0};
        fv[4] = '{32'hFFFF_FC08, 8'd2,  word_of(1, 2),  1'b0};
        fv[5] = '{32'h0000_004A, 8'd18, word_of(1, 18), 1'b0};
        fv[6] = '{32'h0000_000C, 8'd3,  word_of(1, 3),  1'b1};

`ifdef IMEM_CTRL_DBG_EN
        dv[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd5};
        dv[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd4};
        dv[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd5};
        dv[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd4};
`else
        dv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd4};
        dv[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd4};
        dv[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd4};
        dv[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd4};
`endif

        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.ld_last  = 1'b0;
        bus.reload   = 1'b0;
        bus.fetch_pc = '0;
        bus.dbg_req  = 1'b0;
        bus.dbg_addr = '0;
        rst_n        = 1'b0;
        #3;
        check_reset_outputs("rst_init");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ptr_m        = 0;
        in_boot_m    = 1'b1;
        boot_words_m = 0;

        // 19-word program, ld_last on the 19th, valid toggling.
        load_words(1, 19, 1'b1, 1'b1);

        // Combinational fetch, wrap and sticky misalignment.
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            bus.fetch_pc = fv[i].pc;
            @(negedge clk);
            chk("fetch_mem_addr",    64'(bus.mem_addr),     64'(fv[i].addr));
            chk("fetch_instr",       64'(bus.fetch_instr),  64'(fv[i].instr));
            chk("fetch_core_stall",  64'(bus.core_stall),   64'(0));
            chk("fetch_misalign",    64'(bus.misalign_err), 64'(fv[i].mis));
        end
        @(posedge clk); #1;
        bus.fetch_pc = 32'h0000_0010;
        @(negedge clk);
        chk("misalign_sticky", 64'(bus.misalign_err), 64'(1));

        // Debug request held for four cycles against core fetches of word 4.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.dbg_req  = dv[i].req;
            bus.dbg_addr = AW'(5);
            if (dv[i].gnt) exp_dbg_q.push_back(word_of(1, 5));
            @(negedge clk);
            chk("dbg_gnt",         64'(bus.dbg_gnt),     64'(dv[i].gnt));
            chk("dbg_core_stall",  64'(bus.core_stall),  64'(dv[i].stall));
            chk("dbg_rvalid",      64'(bus.dbg_rvalid),  64'(dv[i].rvalid));
            chk("dbg_mem_addr",    64'(bus.mem_addr),    64'(dv[i].addr));
            chk("dbg_fetch_instr", 64'(bus.fetch_instr), 64'(word_of(1, 4)));
        end
        @(posedge clk); #1;
        bus.dbg_req = 1'b0;
        @(negedge clk);
        chk("dbg_idle_gnt",    64'(bus.dbg_gnt),    64'(0));
        chk("dbg_idle_rvalid", 64'(bus.dbg_rvalid), 64'(0));

        // Reload, then a 3-word program.
        do_reload();
        load_words(2, 3, 1'b1, 1'b0);

        // Reload, then 300 words without ld_last: only 256 land.
        do_reload();
        load_words(3, 300, 1'b0, 1'b0);

        // Reset asynchronously while the 8th word is on the load port.
        do_reload();
        load_words(4, 7, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.ld_valid = 1'b1;
        bus.ld_data  = word_of(4, 7);
        #2;
        rst_n        = 1'b0;
        bus.ld_valid = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        ptr_m        = 0;
        in_boot_m    = 1'b1;
        boot_words_m = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        load_words(5, 4, 1'b1, 1'b0);

        @(posedge clk); #1;
        chk("wr_queue_empty",  64'(exp_wr_q.size()),  64'(0));
        chk("dbg_queue_empty", 64'(exp_dbg_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_controller.md
# imem_controller

Sequencer and arbiter for the single-port instruction memory (DEPTH×WIDTH words, combinational read, synchronous write). After reset it holds the core stalled while a program is streamed into memory over a valid/ready load port. It then hands the read port to the core's fetch path and time-shares it with an optional debug read port.

## Interface
- DEPTH, 256, memory depth in words
- WIDTH, 32, word width
- AW, $clog2(DEPTH), word-address width (derived, not overridden)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ld_valid  in  1  load word valid
- ld_ready  out  1  load word accepted when valid&&ready
- ld_data  in  WIDTH  program word
- ld_last  in  1  final word of program
- reload  in  1  RUN-state pulse: restart loading
- fetch_pc  in  32  core byte address
- fetch_instr  out  WIDTH  instruction to core
- core_stall  out  1  core must hold PC/pipeline
- misalign_err  out  1  sticky: fetch_pc[1:0]!=0 seen in RUN
- boot_words  out  AW+1  words loaded in last boot
- dbg_req  in  1  debug read request
- dbg_addr  in  AW  debug word address
- dbg_gnt  out  1  debug granted this cycle
- dbg_rvalid  out  1  dbg_rdata valid (one cycle)
- dbg_rdata  out  WIDTH  registered debug read data
- mem_addr  out  AW  memory word address
- mem_we  out  1  memory write enable
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  memory read data (combinational)

## Operation
- States: BOOT, RUN. Reset → BOOT, load pointer 0.
- BOOT: ld_ready=1, core_stall=1. On accept: mem_we=1, mem_addr=pointer, mem_wdata=ld_data, pointer++.
- BOOT→RUN on the edge after accepting a word with ld_last=1, or the word at pointer DEPTH-1 (implicit last; no wrap). boot_words latched = pointer+1.
- Accepting ld_last as the first word gives boot_words=1.
- RUN: ld_ready=0, mem_we=0. Default owner is the core: mem_addr=fetch_pc[AW+1:2], fetch_instr=mem_rdata, core_stall=0.
- Debug arbitration in RUN: dbg_gnt=dbg_req && !gnt_prev. Debug is never granted two consecutive cycles, so the core owns the port at least every other cycle.
- While dbg_gnt=1: mem_addr=dbg_addr, core_stall=1, fetch_instr holds its value from the previous cycle.
- misalign_err is set in RUN when fetch_pc[1:0]!=0 and core_stall=0. It is cleared only by reset. The fetch still uses the truncated index.
- fetch_pc bits above AW+1 are ignored (address wraps modulo DEPTH).
- reload=1 in RUN → BOOT next edge: pointer 0, any coincident dbg_req is not granted, boot_words keeps its old value until the next boot completes. reload is ignored in BOOT.
- dbg_req in BOOT is never granted.

## Timing
- Load write: zero-latency, same cycle as the accept. Max throughput 1 word/cycle.
- The RUN state is visible (core_stall=0) in the cycle after the last accept.
- Fetch: combinational, 0 cycles, fetch_pc→fetch_instr.
- Debug: dbg_gnt is combinational in cycle N. dbg_rvalid=1 and dbg_rdata=mem_rdata@N in cycle N+1, for one cycle only.
- Reset (asynchronous, any time, including mid-load or mid-debug):
  - state BOOT, pointer 0
  - ld_ready=1, core_stall=1, mem_we=0 (ld_valid low)
  - dbg_gnt=0, dbg_rvalid=0, dbg_rdata=0
  - misalign_err=0, boot_words=0, fetch_instr=0
  - memory contents untouched

## Configuration
- IMEM_CTRL_DBG_EN defined: debug port and arbiter are present, as described above.
- IMEM_CTRL_DBG_EN undefined: dbg_gnt, dbg_rvalid and dbg_rdata are tied to 0, dbg_req and dbg_addr are ignored, and the core owns the port every RUN cycle.

## Structure
- Package imem_ctrl_pkg holds:
  - state typedef (BOOT, RUN)
  - default DEPTH and WIDTH constants
  - WORD_OFFSET=2, the byte-to-word shift
- One sub-module: imem_dbg_arb, the 2-requester alternating arbiter (gnt_prev register, grant logic). It is instantiated only under IMEM_CTRL_DBG_EN.

## Test plan
- Load 19 words, ld_last on the 19th, with ld_valid toggling → exactly 19 writes at addresses 0..18; core_stall falls the cycle after the last accept; boot_words=19.
- Stream 300 words with no ld_last (DEPTH=256) → 256 writes; ld_ready drops after address 255; boot_words=256; no write to address 0 a second time.
- RUN, fetch_pc=0x48 → mem_addr=18, fetch_instr=mem_rdata the same cycle. fetch_pc=0x4A → misalign_err=1 and stays 1.
- RUN, dbg_req held high for 4 cycles with dbg_addr=5 → dbg_gnt pattern 1,0,1,0; core_stall follows the same pattern; dbg_rvalid pattern 0,1,0,1 with dbg_rdata=word 5.
- reload pulse in RUN, then load 3 words → state returns to BOOT, writes go to 0..2, boot_words=3 after the last accept.
- rst_n asserted mid-load at word 7 → all outputs reach reset values immediately; after release, loading restarts at address 0.
